// File: rtl/draw_pkg.sv
// Shared types and constants for the draw pipeline that feeds vga_adapter.
package draw_pkg;

   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;
   localparam int COLOUR_W = 12;

   localparam logic MODE_FILL   = 1'b0;
   localparam logic MODE_SPRITE = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } blit_state_t;

   typedef struct packed {
      logic       valid;
      logic       mode;
      logic [9:0] x;
      logic [8:0] y;
   } blit_tag_t;

   function automatic logic on_screen(input logic [9:0] px, input logic [8:0] py);
      return (px < 10'(SCREEN_W)) && (py < 9'(SCREEN_H));
   endfunction

endpackage

// File: rtl/blit_delay_line.sv
// Fixed-depth shift register that carries the per-pixel issue tag alongside the ROM read.
module blit_delay_line
   import draw_pkg::*;
#(
   parameter int DEPTH = 1
)(
   input  logic      clk,
   input  logic      rst,
   input  blit_tag_t d,
   output blit_tag_t q
);

   blit_tag_t stage_r [DEPTH];

   // Advance every tag one stage per clock; reset empties the pipe so nothing plots afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= '0;
         end
      end else begin
         stage_r[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/sprite_blitter.sv
// Rectangle fill / sprite copy engine: walks the rectangle row-major, reads the image ROM
// and emits one clipped, colour-keyed pixel per clock to vga_adapter.
module sprite_blitter
   import draw_pkg::*;
#(
   parameter int                  ADDR_W      = 17,
   parameter int                  ROM_LAT     = 1,
   parameter logic [COLOUR_W-1:0] TRANSPARENT = 12'hF0F
)(
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_mode,
   input  logic [8:0]          cmd_x,
   input  logic [7:0]          cmd_y,
   input  logic [8:0]          cmd_w,
   input  logic [7:0]          cmd_h,
   input  logic [COLOUR_W-1:0] cmd_colour,
   input  logic [ADDR_W-1:0]   cmd_base,
   output logic [ADDR_W-1:0]   rom_address,
   input  logic [COLOUR_W-1:0] rom_q,
   output logic [8:0]          x,
   output logic [7:0]          y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                done
);

   localparam int DCNT_W = $clog2(ROM_LAT + 1);

   blit_state_t         state_r;
   logic                mode_r;
   logic [8:0]          x0_r;
   logic [7:0]          y0_r;
   logic [8:0]          w_r;
   logic [7:0]          h_r;
   logic [COLOUR_W-1:0] fill_r;
   logic [8:0]          col_r;
   logic [7:0]          row_r;
   logic [DCNT_W-1:0]   drain_r;

   blit_tag_t           issue_s;
   blit_tag_t           tag_s;
   logic                empty_s;
   logic                plot_s;

   assign empty_s = (cmd_w == 9'd0) || (cmd_h == 8'd0);

   // Screen coordinate of the pixel whose ROM address is being presented this cycle.
   always_comb begin
      issue_s.valid = (state_r == RUN);
      issue_s.mode  = mode_r;
      issue_s.x     = {1'b0, x0_r} + {1'b0, col_r};
      issue_s.y     = {1'b0, y0_r} + {1'b0, row_r};
   end

   blit_delay_line #(
      .DEPTH (ROM_LAT)
   ) u_delay (
      .clk (CLOCK_50),
      .rst (reset),
      .d   (issue_s),
      .q   (tag_s)
   );

   // Clip against the visible screen and drop colour-keyed sprite pixels.
   always_comb begin
      plot_s = tag_s.valid && on_screen(tag_s.x, tag_s.y) &&
               ((tag_s.mode == MODE_FILL) || (rom_q != TRANSPARENT));
   end

   // Command FSM with rectangle walk and ROM address counter.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         cmd_ready   <= 1'b1;
         done        <= 1'b0;
         rom_address <= '0;
         mode_r      <= MODE_FILL;
         x0_r        <= 9'd0;
         y0_r        <= 8'd0;
         w_r         <= 9'd0;
         h_r         <= 8'd0;
         fill_r      <= '0;
         col_r       <= 9'd0;
         row_r       <= 8'd0;
         drain_r     <= '0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (cmd_valid) begin
                  mode_r      <= cmd_mode;
                  x0_r        <= cmd_x;
                  y0_r        <= cmd_y;
                  w_r         <= cmd_w;
                  h_r         <= cmd_h;
                  fill_r      <= cmd_colour;
                  rom_address <= cmd_base;
                  col_r       <= 9'd0;
                  row_r       <= 8'd0;
                  drain_r     <= '0;
                  cmd_ready   <= 1'b0;
                  state_r     <= empty_s ? DRAIN : RUN;
               end
            end
            RUN: begin
               rom_address <= rom_address + ADDR_W'(1);
               if (col_r == w_r - 9'd1) begin
                  col_r <= 9'd0;
                  if (row_r == h_r - 8'd1) begin
                     state_r <= DRAIN;
                  end else begin
                     row_r <= row_r + 8'd1;
                  end
               end else begin
                  col_r <= col_r + 9'd1;
               end
            end
            DRAIN: begin
               // Hold until the last ROM read has reached the output register.
               if (drain_r == DCNT_W'(ROM_LAT)) begin
                  state_r   <= IDLE;
                  cmd_ready <= 1'b1;
                  done      <= 1'b1;
               end else begin
                  drain_r <= drain_r + DCNT_W'(1);
               end
            end
            default: begin
               state_r   <= IDLE;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

   // Pixel output register; coordinates and colour hold while nothing is plotted.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         plot   <= 1'b0;
         x      <= 9'd0;
         y      <= 8'd0;
         colour <= '0;
      end else begin
         plot <= plot_s;
         if (plot_s) begin
            x      <= tag_s.x[8:0];
            y      <= tag_s.y[7:0];
            colour <= (tag_s.mode == MODE_SPRITE) ? rom_q : fill_r;
         end
      end
   end

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: ROM_LAT=1 and ROM_LAT=3 instances share one command stream and
// are scored cycle by cycle against a model expanded from each accepted command.
`timescale 1ns/1ps
module tb_sprite_blitter;

   localparam int AW = 17;
   localparam int NI = 2;

   logic            CLOCK_50 = 1'b0;
   logic            reset = 1'b0;
   logic            cmd_valid [NI];
   logic            cmd_ready [NI];
   logic            cmd_mode;
   logic [8:0]      cmd_x;
   logic [7:0]      cmd_y;
   logic [8:0]      cmd_w;
   logic [7:0]      cmd_h;
   logic [11:0]     cmd_colour;
   logic [AW-1:0]   cmd_base;
   logic [AW-1:0]   rom_address [NI];
   logic [11:0]     rom_q [NI];
   logic [8:0]      dut_x [NI];
   logic [7:0]      dut_y [NI];
   logic [11:0]     dut_colour [NI];
   logic            dut_plot [NI];
   logic            dut_done [NI];

   logic [11:0]     mem [1 << AW];

   always #10 CLOCK_50 = ~CLOCK_50;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int L = (gi == 0) ? 1 : 3;
      logic [11:0] q_pipe [L];

      always @(posedge CLOCK_50) begin
         q_pipe[0] <= mem[rom_address[gi]];
         for (int j = 1; j < L; j++) q_pipe[j] <= q_pipe[j-1];
      end
      assign rom_q[gi] = q_pipe[L-1];

      sprite_blitter #(.ADDR_W(AW), .ROM_LAT(L), .TRANSPARENT(12'hF0F)) u_dut (
         .CLOCK_50    (CLOCK_50),
         .reset       (reset),
         .cmd_valid   (cmd_valid[gi]),
         .cmd_ready   (cmd_ready[gi]),
         .cmd_mode    (cmd_mode),
         .cmd_x       (cmd_x),
         .cmd_y       (cmd_y),
         .cmd_w       (cmd_w),
         .cmd_h       (cmd_h),
         .cmd_colour  (cmd_colour),
         .cmd_base    (cmd_base),
         .rom_address (rom_address[gi]),
         .rom_q       (rom_q[gi]),
         .x           (dut_x[gi]),
         .y           (dut_y[gi]),
         .colour      (dut_colour[gi]),
         .plot        (dut_plot[gi]),
         .done        (dut_done[gi])
      );
   end

   typedef struct packed {
      logic        plot;
      logic [8:0]  x;
      logic [7:0]  y;
      logic [11:0] c;
   } pix_t;

   typedef struct {
      logic        mode;
      int          x, y, w, h;
      logic [11:0] colour;
      int          base;
      int          exp_plots;
   } vec_t;

   pix_t         exp_pix  [longint];
   longint       exp_addr [longint];
   longint       cyc = 0;
   longint       hs_cyc    [NI];
   longint       done_cyc  [NI];
   longint       free_cyc  [NI];
   longint       done_seen [NI];
   int           plots_seen [NI];
   logic [8:0]   last_x [NI];
   logic [7:0]   last_y [NI];
   logic [11:0]  last_c [NI];
   int           n_vec = 0;
   int           n_err = 0;

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   task automatic chk(input string name, input int i, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s (ROM_LAT=%0d) cycle %0d: got %0h, want %0h", name, lat_of(i), cyc, act, exp);
      end
   endtask

   // Expand an accepted command into per-cycle expectations using the plain rectangle rules.
   task automatic model_accept(input int i, input longint t);
      int n, lat;
      lat = lat_of(i);
      n = int'(cmd_w) * int'(cmd_h);
      for (int k = 0; k < n; k++) begin
         int col, row, px, py;
         logic [AW-1:0] a;
         logic [11:0] c;
         pix_t p;
         col = k % int'(cmd_w);
         row = k / int'(cmd_w);
         px = int'(cmd_x) + col;
         py = int'(cmd_y) + row;
         a = cmd_base + AW'(k);
         c = cmd_mode ? mem[a] : cmd_colour;
         p.plot = (px < 320) && (py < 240) && (!cmd_mode || c != 12'hF0F);
         p.x = px[8:0];
         p.y = py[7:0];
         p.c = c;
         exp_addr[(t + k) * 2 + i] = longint'(a);
         exp_pix[(t + 1 + lat + k) * 2 + i] = p;
      end
      hs_cyc[i]   = t;
      done_cyc[i] = t + n + lat + 1;
      free_cyc[i] = t + n + lat + 1;
   endtask

   task automatic check_outputs();
      for (int i = 0; i < NI; i++) begin
         longint key;
         logic ep;
         pix_t p;
         key = cyc * 2 + i;
         ep = 1'b0;
         if (reset) begin
            chk("rst_rom_address", i, rom_address[i], 0);
         end else begin
            if (exp_pix.exists(key)) begin
               p = exp_pix[key];
               exp_pix.delete(key);
               ep = p.plot;
               if (p.plot) begin
                  last_x[i] = p.x;
                  last_y[i] = p.y;
                  last_c[i] = p.c;
               end
            end
            if (exp_addr.exists(key)) begin
               chk("rom_address", i, rom_address[i], exp_addr[key]);
               exp_addr.delete(key);
            end
         end
         chk("plot", i, dut_plot[i], ep);
         chk("x", i, dut_x[i], last_x[i]);
         chk("y", i, dut_y[i], last_y[i]);
         chk("colour", i, dut_colour[i], last_c[i]);
         chk("done", i, dut_done[i], (!reset && cyc == done_cyc[i]) ? 1 : 0);
         chk("cmd_ready", i, cmd_ready[i], (reset || cyc >= free_cyc[i]) ? 1 : 0);
         if (dut_plot[i]) plots_seen[i]++;
         if (dut_done[i]) done_seen[i] = cyc;
      end
   endtask

   task automatic tick();
      bit hs [NI];
      for (int i = 0; i < NI; i++) hs[i] = !reset && cmd_valid[i] && cmd_ready[i];
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      cyc++;
      for (int i = 0; i < NI; i++) begin
         if (hs[i]) begin
            model_accept(i, cyc);
            cmd_valid[i] = 1'b0;
         end
      end
      check_outputs();
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      exp_pix.delete();
      exp_addr.delete();
      for (int i = 0; i < NI; i++) begin
         done_cyc[i] = -1;
         free_cyc[i] = 0;
         last_x[i] = 9'd0;
         last_y[i] = 8'd0;
         last_c[i] = 12'd0;
         cmd_valid[i] = 1'b0;
      end
      #1;
      for (int i = 0; i < NI; i++) begin
         chk("async_rst_plot", i, dut_plot[i], 0);
         chk("async_rst_done", i, dut_done[i], 0);
         chk("async_rst_ready", i, cmd_ready[i], 1);
      end
   endtask

   task automatic send_cmd(input logic m, input int px, input int py, input int w, input int h,
                           input logic [11:0] c, input int b);
      int n;
      cmd_mode = m;
      cmd_x = 9'(px);
      cmd_y = 8'(py);
      cmd_w = 9'(w);
      cmd_h = 8'(h);
      cmd_colour = c;
      cmd_base = AW'(b);
      for (int i = 0; i < NI; i++) cmd_valid[i] = 1'b1;
      n = 0;
      while (n < 3000 && (cmd_valid[0] || cmd_valid[1])) begin
         tick();
         n++;
      end
      for (int i = 0; i < NI; i++) begin
         chk("accept_timeout", i, cmd_valid[i], 0);
         cmd_valid[i] = 1'b0;
      end
   endtask

   task automatic wait_done_all(input int budget);
      int n;
      n = 0;
      while (n < budget && !(done_seen[0] > hs_cyc[0] && done_seen[1] > hs_cyc[1])) begin
         tick();
         n++;
      end
      for (int i = 0; i < NI; i++) chk("done_timeout", i, (done_seen[i] > hs_cyc[i]) ? 1 : 0, 1);
   endtask

   initial begin
      vec_t   tbl [5];
      int     p0 [NI];
      longint t0 [NI];

      for (int i = 0; i < (1 << AW); i++) mem[i] = 12'(i);
      mem[100] = 12'hF0F;
      mem[101] = 12'h123;
      for (int i = 0; i < NI; i++) begin
         cmd_valid[i] = 1'b0;
         hs_cyc[i] = -1;
         done_seen[i] = -1;
         plots_seen[i] = 0;
      end
      cmd_mode = 1'b0; cmd_x = 9'd0; cmd_y = 8'd0; cmd_w = 9'd0; cmd_h = 8'd0;
      cmd_colour = 12'd0; cmd_base = '0;

      tbl[0] = '{mode: 1'b0, x: 10,  y: 20,  w: 4, h: 2, colour: 12'h884, base: 0,   exp_plots: 8};
      tbl[1] = '{mode: 1'b1, x: 66,  y: 6,   w: 8, h: 8, colour: 12'h000, base: 0,   exp_plots: 64};
      tbl[2] = '{mode: 1'b1, x: 40,  y: 50,  w: 2, h: 1, colour: 12'h000, base: 100, exp_plots: 1};
      tbl[3] = '{mode: 1'b0, x: 316, y: 238, w: 8, h: 4, colour: 12'hABC, base: 0,   exp_plots: 8};
      tbl[4] = '{mode: 1'b0, x: 5,   y: 5,   w: 0, h: 5, colour: 12'h555, base: 0,   exp_plots: 0};

      #5;
      apply_reset();
      repeat (3) tick();
      reset = 1'b0;
      tick();

      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < NI; i++) p0[i] = plots_seen[i];
         send_cmd(tbl[v].mode, tbl[v].x, tbl[v].y, tbl[v].w, tbl[v].h, tbl[v].colour, tbl[v].base);
         wait_done_all(500);
         tick();
         for (int i = 0; i < NI; i++) begin
            chk("tbl_plots", i, plots_seen[i] - p0[i], tbl[v].exp_plots);
            chk("tbl_done_latency", i, done_seen[i] - hs_cyc[i], tbl[v].w * tbl[v].h + lat_of(i) + 1);
         end
      end

      // Zero-size command followed by a command held pending: it must be taken right at done.
      send_cmd(1'b0, 7, 7, 3, 0, 12'h0F0, 0);
      for (int i = 0; i < NI; i++) t0[i] = hs_cyc[i];
      send_cmd(1'b0, 30, 30, 3, 2, 12'h321, 0);
      for (int i = 0; i < NI; i++) chk("b2b_accept_cycle", i, hs_cyc[i], t0[i] + lat_of(i) + 2);
      wait_done_all(500);

      // Reset part-way through an 8x8 sprite, then a fresh command must run cleanly.
      send_cmd(1'b1, 100, 100, 8, 8, 12'h000, 200);
      repeat (20) tick();
      apply_reset();
      repeat (2) tick();
      reset = 1'b0;
      tick();
      for (int i = 0; i < NI; i++) p0[i] = plots_seen[i];
      send_cmd(1'b0, 1, 2, 3, 3, 12'h777, 0);
      wait_done_all(500);
      for (int i = 0; i < NI; i++) chk("post_reset_plots", i, plots_seen[i] - p0[i], 9);

      // Random commands, sometimes issued while the engine is still busy.
      for (int r = 0; r < 14; r++) begin
         send_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 511)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 24)), int'($urandom_range(0, 10)), 12'($urandom),
                  (r == 3) ? 131066 : int'($urandom_range(0, 131071)));
         if ($urandom_range(0, 1) == 1) wait_done_all(1000);
      end
      wait_done_all(1000);
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
